pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard control for a 5-stage in-order pipeline. This block combines three
// hazard sources into one set of pipeline control signals:
//   - data-memory stalls: a small FSM tracks outstanding accesses and halts
//     the pipeline if the memory never answers,
//   - load-use hazards between EX and ID,
//   - taken branches resolved in ID.
//
// Ports
//   clk_i            sole clock, all state updates on posedge
//   rst_i            synchronous, active-high reset
//   IDEX_MemRead_i   instruction in EX is a load
//   IDEX_Rd_i        destination register of instruction in EX
//   IFID_Rs1_i       first source register of instruction in ID
//   IFID_Rs2_i       second source register of instruction in ID
//   Branch_taken_i   branch in ID resolved taken
//   dmem_req_i       MEM stage issues a data-memory access this cycle
//   dmem_ack_i       data memory completes the access this cycle
//   PCWrite_o        PC update enable
//   IFID_Stall_o     hold IF/ID register
//   IFID_Flush_o     clear IF/ID register
//   IDEX_Bubble_o    insert NOP into ID/EX
//   Global_Stall_o   freeze all pipeline registers
//   stall_cnt_o      saturating count of stall cycles
//   flush_cnt_o      saturating count of flush cycles
//   err_o            sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rd_i,
    input  logic [4:0]  IFID_Rs1_i,
    input  logic [4:0]  IFID_Rs2_i,
    input  logic        Branch_taken_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ack_i,
    output logic        PCWrite_o,
    output logic        IFID_Stall_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Bubble_o,
    output logic        Global_Stall_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e      state_q;
    logic [7:0]  wcnt_q;
    logic        err_q;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;
    logic        memstall;
    logic        loaduse;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- memory-wait FSM ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // An ack in the request cycle completes immediately.
                    if (dmem_req_i && !dmem_ack_i) begin
                        state_q <= MEM_WAIT;
                        wcnt_q  <= 8'd1;
                    end else begin
                        wcnt_q  <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        state_q <= IDLE;
                        wcnt_q  <= 8'd0;
                    end else if (wcnt_q == TIMEOUT) begin
                        state_q <= HALT;
                        err_q   <= 1'b1;
                    end else begin
                        wcnt_q  <= wcnt_q + 8'd1;
                    end
                end
                HALT: begin
                    // Only reset leaves HALT.
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    wcnt_q  <= 8'd0;
                end
            endcase
        end
    end

    // ---- hazard detection ----
    always_comb begin
        memstall = ((state_q == IDLE) && dmem_req_i && !dmem_ack_i) ||
                   ((state_q == MEM_WAIT) && !dmem_ack_i) ||
                   (state_q == HALT);
        loaduse  = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                   ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
    end

    // ---- control outputs (same-cycle, priority memstall > loaduse > branch) ----
    always_comb begin
        PCWrite_o      = 1'b1;
        IFID_Stall_o   = 1'b0;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        Global_Stall_o = 1'b0;
        if (rst_i) begin
            // Keep the front end empty while reset is held.
            PCWrite_o    = 1'b0;
            IFID_Flush_o = 1'b1;
        end else if (memstall) begin
            // ID is frozen here, so a taken branch is still presented
            // and gets flushed on the first free cycle.
            PCWrite_o      = 1'b0;
            IFID_Stall_o   = 1'b1;
            Global_Stall_o = 1'b1;
        end else if (loaduse) begin
            PCWrite_o     = 1'b0;
            IFID_Stall_o  = 1'b1;
            IDEX_Bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    // ---- event counters ----
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (memstall || loaduse) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end
        if (IFID_Flush_o) begin
            flush_cnt_d = sat_inc16(flush_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Drives directed and random cycles into pipeline_hazard_ctrl (TIMEOUT=4).
// For every cycle the driver computes the expected outputs from a behavioural
// model and queues them; a monitor compares the DUT against the queue at the
// falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] TO = 8'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        br = 1'b0;
    logic        req = 1'b0;
    logic        ack = 1'b0;
    logic        pcw, ifst, iffl, bub, gst, err;
    logic [15:0] scnt, fcnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .IDEX_MemRead_i (mr),
        .IDEX_Rd_i      (rd),
        .IFID_Rs1_i     (rs1),
        .IFID_Rs2_i     (rs2),
        .Branch_taken_i (br),
        .dmem_req_i     (req),
        .dmem_ack_i     (ack),
        .PCWrite_o      (pcw),
        .IFID_Stall_o   (ifst),
        .IFID_Flush_o   (iffl),
        .IDEX_Bubble_o  (bub),
        .Global_Stall_o (gst),
        .stall_cnt_o    (scnt),
        .flush_cnt_o    (fcnt),
        .err_o          (err)
    );

    typedef struct packed {
        logic        pcw;
        logic        st;
        logic        fl;
        logic        bb;
        logic        gs;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Behavioural model: an outstanding access either is pending for m_wait
    // cycles, or the pipeline is dead until reset.
    bit m_busy = 0;
    bit m_halt = 0;
    int m_wait = 0;
    int m_sc = 0;
    int m_fc = 0;
    bit m_err = 0;

    task automatic step(input bit r, input bit i_mr, input logic [4:0] i_rd,
                        input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                        input bit i_br, input bit i_req, input bit i_ack);
        exp_t e;
        bit   ms, lu;
        @(posedge clk);
        #1;
        rst = r; mr = i_mr; rd = i_rd; rs1 = i_rs1; rs2 = i_rs2;
        br = i_br; req = i_req; ack = i_ack;
        ms = m_halt || (m_busy && !i_ack) || (!m_busy && i_req && !i_ack);
        lu = i_mr && (i_rd != 0) && (i_rd == i_rs1 || i_rd == i_rs2);
        e = '0;
        e.sc = m_sc[15:0];
        e.fc = m_fc[15:0];
        e.er = m_err;
        if (r) begin
            e.fl = 1;
        end else if (ms) begin
            e.gs = 1; e.st = 1;
        end else if (lu) begin
            e.st = 1; e.bb = 1;
        end else if (i_br) begin
            e.fl = 1; e.pcw = 1;
        end else begin
            e.pcw = 1;
        end
        q.push_back(e);
        // state after the coming edge
        if (r) begin
            m_busy = 0; m_halt = 0; m_wait = 0; m_sc = 0; m_fc = 0; m_err = 0;
        end else begin
            if (ms || lu) m_sc = (m_sc >= 65535) ? 65535 : m_sc + 1;
            if (e.fl)     m_fc = (m_fc >= 65535) ? 65535 : m_fc + 1;
            if (m_halt) begin
                // stuck
            end else if (m_busy) begin
                if (i_ack) begin
                    m_busy = 0; m_wait = 0;
                end else if (m_wait == int'(TO)) begin
                    m_halt = 1; m_err = 1;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else if (i_req && !i_ack) begin
                m_busy = 1; m_wait = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: one expected record per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("PCWrite",      {15'd0, pcw},  {15'd0, e.pcw});
                chk("IFID_Stall",   {15'd0, ifst}, {15'd0, e.st});
                chk("IFID_Flush",   {15'd0, iffl}, {15'd0, e.fl});
                chk("IDEX_Bubble",  {15'd0, bub},  {15'd0, e.bb});
                chk("Global_Stall", {15'd0, gst},  {15'd0, e.gs});
                chk("stall_cnt",    scnt,          e.sc);
                chk("flush_cnt",    fcnt,          e.fc);
                chk("err",          {15'd0, err},  {15'd0, e.er});
            end
        end
    end

    initial begin
        // reset
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        idle(2);
        // load-use Rd=5, Rs1=5
        step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        idle(1);
        // load-use on Rs2, and branch ignored during load-use
        step(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0);
        // Rd=0 never stalls
        step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        // memory ack three cycles after request
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        idle(1);
        // ack in the request cycle
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        // branch held through a 2-cycle memstall, plus a load-use under memstall
        step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        step(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1);
        idle(1);
        // timeout: never acked
        for (int k = 0; k < 8; k++) step(0, 0, 5'd0, 5'd0, 5'd0, k[0], 1, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle(2);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            bit r;
            r = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            step(r, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        // saturation: HALT keeps memstall asserted indefinitely
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int k = 0; k < 65600; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(posedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
